gain_apply: RTL and testbench

- Consumer side of the channel-gain calibration: takes the averaged 12-bit `gain` and `calvalid` from the calibration block and applies that gain to a complex FFT-bin stream (24-bit re/im) for equalisation or pre-compensation.
- Sits downstream of the FFT output, in the same clock domain as the calibration block.
- Gain changes are frame-aligned: a new gain never takes effect mid-frame.

---
 rtl/gain_apply.sv | 188 ++++++++++++++++++
 tb/tb_gain_apply.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/gain_apply.sv
// Applies the calibrated channel gain to a complex FFT-bin stream.
// New gains are held pending and only take effect at the next frame start (bin 0).
module gain_apply #(
  parameter int NFFT      = 2048,
  parameter int GAIN_FRAC = 8,
  parameter int UNITY     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] gain,
  input  logic        calvalid,
  input  logic        in_valid,
  input  logic [23:0] in_re,
  input  logic [23:0] in_im,
  output logic        out_valid,
  output logic [23:0] out_re,
  output logic [23:0] out_im,
  output logic        out_last,
  output logic [11:0] gain_active,
  output logic        sat_flag
);

  localparam int                 CW       = $clog2(NFFT);
  localparam logic [CW-1:0]      LAST_BIN = CW'(NFFT - 1);
  localparam logic [11:0]        UNITY_G  = 12'(UNITY);
  localparam logic signed [36:0] RND      = 37'sd1 <<< (GAIN_FRAC - 1);
  localparam logic signed [36:0] MAX_V    = 37'sd8388607;
  localparam logic signed [36:0] MIN_V    = -37'sd8388608;

  typedef enum logic [1:0] {
    BYPASS,
    ARMED,
    RUN
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic               r_calvalid_d;
  logic               w_cal_edge;
  logic [11:0]        r_gain_pend;
  logic               r_pending;
  logic [CW-1:0]      r_bin_cnt;
  logic [11:0]        r_gain_active;
  logic               w_frame_start;
  logic               w_apply;
  logic [11:0]        w_mult_gain;
  logic signed [12:0] w_gain_ext;
  logic signed [36:0] w_prod_re;
  logic signed [36:0] w_prod_im;

  logic               r_s1_valid;
  logic               r_s1_last;
  logic signed [36:0] r_s1_re;
  logic signed [36:0] r_s1_im;

  logic signed [36:0] w_rnd_re;
  logic signed [36:0] w_rnd_im;
  logic               w_hi_re;
  logic               w_lo_re;
  logic               w_hi_im;
  logic               w_lo_im;
  logic [23:0]        w_sat_re;
  logic [23:0]        w_sat_im;

  logic               r_out_valid;
  logic               r_out_last;
  logic [23:0]        r_out_re;
  logic [23:0]        r_out_im;
  logic               r_sat_flag;

  assign w_cal_edge    = calvalid & ~r_calvalid_d;
  assign w_frame_start = in_valid && (r_bin_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= BYPASS;
    end else begin
      r_state <= w_next_state;
    end
  end

  // The pending flag is checked before this cycle's calvalid edge is folded in,
  // so an edge coinciding with a bin-0 sample waits for the following frame.
  always_comb begin
    w_next_state = r_state;
    w_apply      = 1'b0;
    w_mult_gain  = UNITY_G;
    case (r_state)
      BYPASS: begin
        if (w_cal_edge) begin
          w_next_state = ARMED;
        end
      end
      ARMED, RUN: begin
        w_mult_gain = r_gain_active;
        if (w_frame_start && r_pending) begin
          w_apply      = 1'b1;
          w_mult_gain  = r_gain_pend;
          w_next_state = RUN;
        end
      end
      default: begin
        w_next_state = BYPASS;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_calvalid_d  <= 1'b0;
      r_gain_pend   <= '0;
      r_pending     <= 1'b0;
      r_bin_cnt     <= '0;
      r_gain_active <= UNITY_G;
    end else begin
      r_calvalid_d <= calvalid;
      if (in_valid) begin
        r_bin_cnt <= r_bin_cnt + 1'b1;
      end
      if (w_apply) begin
        r_gain_active <= r_gain_pend;
        r_pending     <= 1'b0;
      end
      if (w_cal_edge) begin
        r_gain_pend <= gain;
        r_pending   <= 1'b1;
      end
    end
  end

  assign w_gain_ext = $signed({1'b0, w_mult_gain});
  assign w_prod_re  = $signed(in_re) * w_gain_ext;
  assign w_prod_im  = $signed(in_im) * w_gain_ext;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_re    <= '0;
      r_s1_im    <= '0;
    end else begin
      r_s1_valid <= in_valid;
      r_s1_last  <= in_valid && (r_bin_cnt == LAST_BIN);
      if (in_valid) begin
        r_s1_re <= w_prod_re;
        r_s1_im <= w_prod_im;
      end
    end
  end

  // Round half toward +inf, then clip to the 24-bit signed range.
  assign w_rnd_re = (r_s1_re + RND) >>> GAIN_FRAC;
  assign w_rnd_im = (r_s1_im + RND) >>> GAIN_FRAC;
  assign w_hi_re  = w_rnd_re > MAX_V;
  assign w_lo_re  = w_rnd_re < MIN_V;
  assign w_hi_im  = w_rnd_im > MAX_V;
  assign w_lo_im  = w_rnd_im < MIN_V;
  assign w_sat_re = w_hi_re ? 24'h7FFFFF : (w_lo_re ? 24'h800000 : w_rnd_re[23:0]);
  assign w_sat_im = w_hi_im ? 24'h7FFFFF : (w_lo_im ? 24'h800000 : w_rnd_im[23:0]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_sat_flag  <= 1'b0;
    end else begin
      r_out_valid <= r_s1_valid;
      r_out_last  <= r_s1_last;
      if (r_s1_valid) begin
        r_out_re <= w_sat_re;
        r_out_im <= w_sat_im;
        if (w_hi_re || w_lo_re || w_hi_im || w_lo_im) begin
          r_sat_flag <= 1'b1;
        end
      end
    end
  end

  assign out_valid   = r_out_valid;
  assign out_last    = r_out_last;
  assign out_re      = r_out_re;
  assign out_im      = r_out_im;
  assign gain_active = r_gain_active;
  assign sat_flag    = r_sat_flag;

endmodule

// File: tb/tb_gain_apply.sv
// Randomised frame-level bench for gain_apply against a behavioural model of
// frame-aligned gain switching and rounded/saturated complex scaling.
module tb_gain_apply;

  localparam int NFFT  = 2048;
  localparam int UNITY = 256;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] gain;
  logic        calvalid;
  logic        in_valid;
  logic [23:0] in_re;
  logic [23:0] in_im;
  logic        out_valid;
  logic [23:0] out_re;
  logic [23:0] out_im;
  logic        out_last;
  logic [11:0] gain_active;
  logic        sat_flag;

  int assertCount = 0;
  int failCount   = 0;

  typedef struct {
    bit     valid;
    bit     last;
    bit     clip;
    longint re;
    longint im;
  } sample_t;

  longint  mActive;
  longint  mPend;
  bit      mPending;
  bit      mPrevCv;
  int      mBin;
  bit      mSat;
  sample_t mPipe[$];
  sample_t mOut;

  gain_apply #(.NFFT(NFFT), .GAIN_FRAC(8), .UNITY(UNITY)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .gain(gain),
    .calvalid(calvalid),
    .in_valid(in_valid),
    .in_re(in_re),
    .in_im(in_im),
    .out_valid(out_valid),
    .out_re(out_re),
    .out_im(out_im),
    .out_last(out_last),
    .gain_active(gain_active),
    .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    assertCount++;
    if (observed != expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // x * gain / 256 rounded half toward +inf, using floor division on signed values.
  function automatic longint scaled(input longint x, input longint g);
    longint q;
    q = x * g + 128;
    if (q >= 0) return q / 256;
    return -((-q + 255) / 256);
  endfunction

  function automatic longint clip24(input longint v);
    if (v > 8388607) return 8388607;
    if (v < -8388608) return -8388608;
    return v;
  endfunction

  task automatic modelReset();
    mActive  = UNITY;
    mPend    = 0;
    mPending = 0;
    mPrevCv  = 0;
    mBin     = 0;
    mSat     = 0;
    mPipe.delete();
    mOut = '{valid: 0, last: 0, clip: 0, re: 0, im: 0};
    mPipe.push_back(mOut);
  endtask

  // A pending gain is swapped in at the first valid sample of a frame; a new
  // calibration edge on that same cycle only becomes pending afterwards.
  task automatic modelStep(input bit v, input longint re, input longint im, input bit cv, input longint g);
    sample_t s;
    longint  useG;
    longint  rawRe;
    longint  rawIm;
    s = '{valid: 0, last: 0, clip: 0, re: 0, im: 0};
    useG = mActive;
    if (v && mBin == 0 && mPending) begin
      useG     = mPend;
      mActive  = mPend;
      mPending = 0;
    end
    if (cv && !mPrevCv) begin
      mPend    = g;
      mPending = 1;
    end
    mPrevCv = cv;
    if (v) begin
      rawRe   = scaled(re, useG);
      rawIm   = scaled(im, useG);
      s.valid = 1;
      s.last  = (mBin == NFFT - 1);
      s.re    = clip24(rawRe);
      s.im    = clip24(rawIm);
      s.clip  = (s.re != rawRe) || (s.im != rawIm);
      mBin    = (mBin + 1) % NFFT;
    end
    mPipe.push_back(s);
    mOut = mPipe.pop_front();
    if (mOut.valid && mOut.clip) mSat = 1;
  endtask

  task automatic checkCycle();
    checkOutput("out_valid", longint'(out_valid), longint'(mOut.valid));
    checkOutput("out_last", longint'(out_last), longint'(mOut.valid && mOut.last));
    if (mOut.valid) begin
      checkOutput("out_re", longint'($signed(out_re)), mOut.re);
      checkOutput("out_im", longint'($signed(out_im)), mOut.im);
    end
    checkOutput("gain_active", longint'(gain_active), mActive);
    checkOutput("sat_flag", longint'(sat_flag), longint'(mSat));
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_out_valid"}, longint'(out_valid), 0);
    checkOutput({tag, "_out_re"}, longint'($signed(out_re)), 0);
    checkOutput({tag, "_out_im"}, longint'($signed(out_im)), 0);
    checkOutput({tag, "_out_last"}, longint'(out_last), 0);
    checkOutput({tag, "_gain_active"}, longint'(gain_active), UNITY);
    checkOutput({tag, "_sat_flag"}, longint'(sat_flag), 0);
  endtask

  task automatic applyStimulus(input bit v, input int re, input int im, input bit cv, input int g);
    in_valid = v;
    in_re    = re[23:0];
    in_im    = im[23:0];
    calvalid = cv;
    gain     = g[11:0];
    @(posedge clk);
    modelStep(v, longint'(re), longint'(im), cv, longint'(g));
    #1;
    checkCycle();
  endtask

  task automatic doMidReset();
    rst_n    = 1'b0;
    in_valid = 1'b0;
    calvalid = 1'b0;
    #1;
    modelReset();
    checkResetValues("midrst");
    repeat (2) begin
      @(posedge clk);
      #1;
      checkCycle();
    end
    rst_n = 1'b1;
  endtask

  function automatic int randFull();
    int r;
    r = int'($urandom);
    return r >>> 8;
  endfunction

  // dataMode: 0 constant 1000/-1000, 1 small values with directed rounding
  // cases at bins 0-1, 2 full-range values with directed clip cases at bins 0-1.
  // gapMode: 0 none, 1 repeating 1,0,1,1,0, 2 random gaps.
  task automatic runFrame(input int dataMode, input int gapMode, input int calBin,
                          input int calGain, input int calGain2, input int resetBin);
    int cnt;
    int cyc;
    bit v;
    bit cv;
    int re;
    int im;
    int g;
    int gapPat[5];
    gapPat = '{1, 0, 1, 1, 0};
    cnt = 0;
    cyc = 0;
    while (cnt < NFFT && cyc < 4 * NFFT) begin
      if (resetBin >= 0 && cnt == resetBin) begin
        doMidReset();
        return;
      end
      case (gapMode)
        0:       v = 1'b1;
        1:       v = gapPat[cyc % 5] != 0;
        default: v = $urandom_range(0, 3) != 0;
      endcase
      case (dataMode)
        0: begin
          re = 1000;
          im = -1000;
        end
        1: begin
          re = int'($urandom_range(0, 2000)) - 1000;
          im = int'($urandom_range(0, 2000)) - 1000;
          if (cnt == 0) begin re = 3;  im = 2; end
          if (cnt == 1) begin re = -3; im = 2; end
        end
        default: begin
          re = randFull();
          im = randFull();
          if (cnt == 0) begin re = 4194304;  im = -4194305; end
          if (cnt == 1) begin re = -4194305; im = 4194304;  end
        end
      endcase
      cv = (calBin >= 0) &&
           ((cnt >= calBin && cnt < calBin + 4) ||
            (calGain2 != calGain && cnt >= calBin + 10 && cnt < calBin + 14));
      g = (cnt < calBin + 8) ? calGain : calGain2;
      applyStimulus(v, re, im, cv, g);
      if (v) cnt++;
      cyc++;
    end
    checkOutput("frame_complete", longint'(cnt), NFFT);
  endtask

  initial begin
    int rg;
    rst_n    = 1'b0;
    gain     = '0;
    calvalid = 1'b0;
    in_valid = 1'b0;
    in_re    = '0;
    in_im    = '0;
    modelReset();
    repeat (2) @(posedge clk);
    #1;
    checkResetValues("reset");
    rst_n = 1'b1;

    $display("[TB] unity bypass frame with gapped input, calibration 512 at bin 100");
    runFrame(0, 1, 100, 512, 512, -1);
    $display("[TB] gain 512 frame, calibration 384 at bin 100");
    runFrame(0, 0, 100, 384, 384, -1);
    $display("[TB] gain 384 rounding frame, calibration 512 at bin 50");
    runFrame(1, 2, 50, 512, 512, -1);
    $display("[TB] gain 512 saturation frame, calibration 0 at bin 300");
    runFrame(2, 2, 300, 0, 0, -1);
    $display("[TB] zero-gain frame, random calibration, reset at bin 700");
    rg = int'($urandom_range(0, 4095));
    runFrame(2, 2, 20, rg, rg, 700);
    $display("[TB] post-reset bypass frame, two calibration edges");
    runFrame(2, 2, 1000, int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), -1);
    $display("[TB] random frame with last-wins gain applied");
    rg = int'($urandom_range(0, 4095));
    runFrame(2, 2, 0, rg, rg, -1);
    repeat (3) applyStimulus(1'b0, 0, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
